signal_safety_monitor: RTL and testbench
========================================

Name: signal_safety_monitor

Overview:
- Downstream of the junction light-sequencing controller; consumes its four 3-bit lamp buses (M1, M2, MT, ST) and drives the physical lamp outputs.
- Checks every cycle for conflicting greens, illegal codes and amber-timing violations.
- On any fault it latches a fault code, forces all-red, then enters amber/red failsafe flashing until an operator clears it.

Parameters:
- MIN_AMBER, 2: minimum consecutive amber cycles required before red.
- ALL_RED_CYC, 4: cycles held in all-red after a fault, before flashing starts.
- FLASH_HALF, 2: cycles per flash half-period.
- INVALID_TOL, 1: consecutive cycles an illegal code is tolerated; the fault fires on cycle INVALID_TOL+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- light_M1_in  in  3  controller lamp code, main approach 1
- light_M2_in  in  3  controller lamp code, main approach 2
- light_MT_in  in  3  controller lamp code, main turn
- light_ST_in  in  3  controller lamp code, side road
- clear_fault  in  1  single-cycle operator clear request
- lamp_M1  out  3  driven lamp, M1
- lamp_M2  out  3  driven lamp, M2
- lamp_MT  out  3  driven lamp, MT
- lamp_ST  out  3  driven lamp, ST
- fault  out  1  sticky fault flag
- fault_code  out  3  first fault cause; 0 = none

Behaviour:
- Lamp encoding is {red, amber, green}:
  - RED = 3'b100, AMB = 3'b010, GRN = 3'b001.
  - Any other value is illegal.
- Reset (synchronous): all lamps RED, fault = 0, fault_code = 0, FSM = NORMAL, per-approach history = RED, all counters = 0.
- FSM states: NORMAL, ALL_RED, FLASH.
- NORMAL:
  - Lamps are a registered copy of the inputs, so latency is 1 cycle.
  - Fault checks run on the current inputs against the registered previous inputs.
- Fault codes (priority is lowest number first when several occur in the same cycle):
  - 1 CONFLICT: ST green together with any other green, or M2 green together with MT green.
  - 2 ILLEGAL: a non-one-hot code on any approach, held for INVALID_TOL+1 consecutive cycles. The illegal code is never forwarded; the lamp holds its previous value while tolerated.
  - 3 SKIP_AMBER: GRN followed directly by RED, or AMB followed directly by GRN.
  - 4 SHORT_AMBER: AMB followed by RED with the consecutive-amber count < MIN_AMBER.
- Amber counter:
  - Per approach; increments while the input is AMB and saturates at MIN_AMBER.
  - Clears when the input is not AMB.
- On a fault detected in cycle N:
  - In cycle N+1: fault = 1, fault_code latched, FSM = ALL_RED, all lamps RED. The faulty inputs are never driven.
- ALL_RED:
  - Hold all lamps RED for ALL_RED_CYC cycles, then go to FLASH.
- FLASH:
  - M1, M2 and MT alternate AMB and all-off (3'b000) every FLASH_HALF cycles, starting with AMB.
  - ST alternates RED and all-off with the same phase.
- Clearing:
  - clear_fault is accepted only in FLASH, and only when all four inputs equal RED in that cycle.
  - When accepted: fault = 0, fault_code = 0, FSM = NORMAL, history reloaded to RED, and lamps follow the inputs from the next cycle.
  - clear_fault in NORMAL or ALL_RED, or with any input not RED, is ignored.
- Further faults while already in ALL_RED or FLASH do not change fault_code (first cause is kept).
- A fault in the same cycle as an accepted clear: the clear wins. The new fault is evaluated from the next NORMAL cycle.
- rst mid-flash or mid-fault returns to the reset state in the next cycle.

Optional Feature:
- Macro: SIGNAL_SAFETY_FAULT_CNT_EN.
- Defined:
  - Adds output fault_cnt [7:0]: a saturating count of fault entries (NORMAL to ALL_RED transitions).
  - Cleared only by rst, not by clear_fault; saturates at 255.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package traffic_pkg holds:
  - Lamp code constants RED, AMB, GRN, OFF.
  - Monitor state encoding NORMAL, ALL_RED, FLASH.
  - Fault code constants 0–4.
- One sub-module, amber_checker, instantiated 4x (one per approach). It holds previous-code history, the amber counter and the illegal-code timer, and outputs the skip, short and illegal flags. The top level does the conflict check, priority, FSM, flashing and lamp muxing.

Test Plan:
- Controller-legal sequence:
  - Stimulus: M1/M2 GRN for 8 cycles; M2 AMB 3 cycles; MT GRN 6; M1/MT AMB 3; ST GRN 4; ST AMB 3.
  - Required: lamps equal inputs delayed 1 cycle, fault stays 0 throughout.
- Conflict:
  - Stimulus: ST = GRN while M1 = GRN in cycle N.
  - Required: cycle N+1 fault = 1, code = 1, all lamps RED for 4 cycles, then M1 = AMB and ST = RED for 2 cycles, then 3'b000 for 2 cycles, repeating.
- Short amber:
  - Stimulus: M2 goes GRN, then AMB for 1 cycle, then RED.
  - Required: code = 4.
  - Stimulus: M2 goes GRN directly to RED.
  - Required: code = 3.
- Illegal code:
  - Stimulus: M1 = 3'b011 for 1 cycle, then GRN.
  - Required: no fault, lamp holds its previous value during the illegal cycle.
  - Stimulus: M1 = 3'b011 for 2 cycles.
  - Required: code = 2.
- Clear:
  - Stimulus: in FLASH, clear_fault with M1 = GRN.
  - Required: ignored.
  - Stimulus: in FLASH, clear_fault with all inputs RED.
  - Required: next cycle fault = 0, code = 0, lamps track inputs.
- Reset and simultaneous faults:
  - Stimulus: rst asserted during FLASH.
  - Required: next cycle all lamps RED, fault = 0.
  - Stimulus: CONFLICT and SHORT_AMBER in the same cycle.
  - Required: code = 1.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the junction signal safety monitor.
// Holds the {red, amber, green} lamp codes, the monitor state encoding,
// the fault cause codes, the default timing parameters and small helpers
// used by the monitor and its per-approach checker.
package traffic_pkg;

  // Lamp codes, bit order {red, amber, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] AMB = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  // Monitor operating states
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ALL_RED = 2'd1,
    FLASH   = 2'd2
  } mon_state_e;

  // Fault causes; a lower number has higher priority
  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_CONFLICT    = 3'd1;
  localparam logic [2:0] FC_ILLEGAL     = 3'd2;
  localparam logic [2:0] FC_SKIP_AMBER  = 3'd3;
  localparam logic [2:0] FC_SHORT_AMBER = 3'd4;

  // Default timing
  localparam int MIN_AMBER_DEF   = 2;
  localparam int ALL_RED_CYC_DEF = 4;
  localparam int FLASH_HALF_DEF  = 2;
  localparam int INVALID_TOL_DEF = 1;

  // A lamp code is legal only when exactly one lamp is lit
  function automatic logic lamp_is_legal(input logic [2:0] code);
    logic legal;
    case (code)
      RED, AMB, GRN: legal = 1'b1;
      default:       legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Failsafe flash pattern: main approaches blink amber, side road blinks red
  function automatic logic [2:0] flash_lamp(input logic is_side, input logic lit);
    logic [2:0] code;
    if (!lit) begin
      code = OFF;
    end else if (is_side) begin
      code = RED;
    end else begin
      code = AMB;
    end
    return code;
  endfunction

endpackage

// File: rtl/signal_safety_monitor_if.sv
// signal_safety_monitor_if: lamp bus between the light-sequencing controller,
// the safety monitor and the physical lamp drivers.
//   light_*_in  : controller lamp codes (M1, M2, MT, ST)
//   clear_fault : single-cycle operator clear request
//   lamp_*      : lamp codes actually driven
//   fault       : sticky fault flag
//   fault_code  : first fault cause, 0 = none
//   fault_cnt   : saturating fault-entry count, only with SIGNAL_SAFETY_FAULT_CNT_EN
// master = controller/operator side, slave = monitor.
interface signal_safety_monitor_if;
  logic [2:0] light_M1_in;
  logic [2:0] light_M2_in;
  logic [2:0] light_MT_in;
  logic [2:0] light_ST_in;
  logic       clear_fault;
  logic [2:0] lamp_M1;
  logic [2:0] lamp_M2;
  logic [2:0] lamp_MT;
  logic [2:0] lamp_ST;
  logic       fault;
  logic [2:0] fault_code;
`ifdef SIGNAL_SAFETY_FAULT_CNT_EN
  logic [7:0] fault_cnt;
`endif

  modport master (
    output light_M1_in, light_M2_in, light_MT_in, light_ST_in, clear_fault,
    input  lamp_M1, lamp_M2, lamp_MT, lamp_ST, fault, fault_code
`ifdef SIGNAL_SAFETY_FAULT_CNT_EN
    , input fault_cnt
`endif
  );

  modport slave (
    input  light_M1_in, light_M2_in, light_MT_in, light_ST_in, clear_fault,
    output lamp_M1, lamp_M2, lamp_MT, lamp_ST, fault, fault_code
`ifdef SIGNAL_SAFETY_FAULT_CNT_EN
    , output fault_cnt
`endif
  );

endinterface

// File: rtl/amber_checker.sv
// amber_checker: per-approach sequence checker.
// Keeps the last legal lamp code, a saturating consecutive-amber counter and
// an illegal-code run timer, and flags the current input against them.
//   clk, rst    : clock, synchronous active-high reset
//   reload      : forces history to RED and clears counters (used outside NORMAL)
//   code_in     : current controller lamp code
//   skip_amber  : GRN->RED or AMB->GRN
//   short_amber : AMB->RED after fewer than MIN_AMBER amber cycles
//   illegal     : illegal code held beyond INVALID_TOL cycles
//   drive_code  : code to drive: the input if legal, else the last legal code
module amber_checker
  import traffic_pkg::*;
#(
  parameter int MIN_AMBER   = MIN_AMBER_DEF,
  parameter int INVALID_TOL = INVALID_TOL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic [2:0] code_in,
  output logic       skip_amber,
  output logic       short_amber,
  output logic       illegal,
  output logic [2:0] drive_code
);

  localparam int AW = $clog2(MIN_AMBER + 2);
  localparam int IW = $clog2(INVALID_TOL + 2);
  localparam logic [AW-1:0] AMB_MAX = AW'(MIN_AMBER);
  localparam logic [IW-1:0] ILL_MAX = IW'(INVALID_TOL);

  logic [2:0]    prev_r;
  logic [AW-1:0] amb_cnt_r;
  logic [IW-1:0] ill_cnt_r;
  logic          legal_s;
  logic          skip_s;
  logic          short_s;
  logic          ill_s;
  logic [2:0]    drive_s;

  assign legal_s = lamp_is_legal(code_in);

  // History of the last legal code, amber run length and illegal run length
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      prev_r    <= RED;
      amb_cnt_r <= {AW{1'b0}};
      ill_cnt_r <= {IW{1'b0}};
    end else begin
      // an illegal code never enters history, so the lamp can keep holding it
      if (legal_s) begin
        prev_r <= code_in;
      end else begin
        prev_r <= prev_r;
      end
      if (code_in == AMB) begin
        if (amb_cnt_r != AMB_MAX) begin
          amb_cnt_r <= amb_cnt_r + AW'(1);
        end
      end else begin
        amb_cnt_r <= {AW{1'b0}};
      end
      if (!legal_s) begin
        if (ill_cnt_r != ILL_MAX) begin
          ill_cnt_r <= ill_cnt_r + IW'(1);
        end
      end else begin
        ill_cnt_r <= {IW{1'b0}};
      end
    end
  end

  // Transition checks of the current input against history
  always_comb begin
    skip_s  = 1'b0;
    short_s = 1'b0;
    ill_s   = 1'b0;
    drive_s = prev_r;
    if (legal_s) begin
      drive_s = code_in;
      skip_s  = ((prev_r == GRN) && (code_in == RED)) ||
                ((prev_r == AMB) && (code_in == GRN));
      short_s = (prev_r == AMB) && (code_in == RED) && (amb_cnt_r < AMB_MAX);
    end else begin
      // ill_cnt_r counts earlier illegal cycles: fire on cycle INVALID_TOL+1
      ill_s = (ill_cnt_r >= ILL_MAX);
    end
  end

  assign skip_amber  = skip_s;
  assign short_amber = short_s;
  assign illegal     = ill_s;
  assign drive_code  = drive_s;

endmodule

// File: rtl/signal_safety_monitor.sv
// signal_safety_monitor: safety monitor between the light-sequencing
// controller and the physical lamps.
//   clk, rst : clock, synchronous active-high reset
//   bus      : signal_safety_monitor_if.slave (controller lamp codes and
//              clear_fault in; driven lamps, fault, fault_code out)
// In NORMAL the lamps are a registered copy of the inputs. Conflicting
// greens, illegal codes and amber timing violations latch the first fault
// cause, force all-red for ALL_RED_CYC cycles, then flash until an operator
// clear arrives while all inputs are RED.
// Optional build macro SIGNAL_SAFETY_FAULT_CNT_EN adds bus.fault_cnt, a
// saturating count of fault entries cleared only by rst.
module signal_safety_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_AMBER   = MIN_AMBER_DEF,
  parameter int ALL_RED_CYC = ALL_RED_CYC_DEF,
  parameter int FLASH_HALF  = FLASH_HALF_DEF,
  parameter int INVALID_TOL = INVALID_TOL_DEF
) (
  input logic                    clk,
  input logic                    rst,
  signal_safety_monitor_if.slave bus
);

  localparam int TMAX = (ALL_RED_CYC > FLASH_HALF) ? ALL_RED_CYC : FLASH_HALF;
  localparam int TW   = $clog2(TMAX + 1);

  // Approach index: 0 = M1, 1 = M2, 2 = MT, 3 = ST
  logic [2:0]  in_s    [4];
  logic [2:0]  drive_s [4];
  logic [2:0]  lamp_r  [4];
  logic [3:0]  skip_s;
  logic [3:0]  short_s;
  logic [3:0]  ill_s;
  logic        conflict_s;
  logic        all_red_s;
  logic        clear_ok_s;
  logic        reload_s;
  logic [2:0]  new_code_s;
  mon_state_e  state_r;
  logic [TW-1:0] tmr_r;
  logic        lit_r;
  logic        fault_r;
  logic [2:0]  code_r;

  assign in_s[0] = bus.light_M1_in;
  assign in_s[1] = bus.light_M2_in;
  assign in_s[2] = bus.light_MT_in;
  assign in_s[3] = bus.light_ST_in;

  // History is meaningless in the fault states; holding it at RED there makes
  // an accepted clear restart checking from a clean all-red history.
  assign reload_s = (state_r != NORMAL);

  for (genvar gi = 0; gi < 4; gi++) begin : g_chk
    amber_checker #(
      .MIN_AMBER   (MIN_AMBER),
      .INVALID_TOL (INVALID_TOL)
    ) u_chk (
      .clk         (clk),
      .rst         (rst),
      .reload      (reload_s),
      .code_in     (in_s[gi]),
      .skip_amber  (skip_s[gi]),
      .short_amber (short_s[gi]),
      .illegal     (ill_s[gi]),
      .drive_code  (drive_s[gi])
    );
  end

  assign conflict_s = ((in_s[3] == GRN) &&
                       ((in_s[0] == GRN) || (in_s[1] == GRN) || (in_s[2] == GRN))) ||
                      ((in_s[1] == GRN) && (in_s[2] == GRN));
  assign all_red_s  = (in_s[0] == RED) && (in_s[1] == RED) &&
                      (in_s[2] == RED) && (in_s[3] == RED);
  assign clear_ok_s = bus.clear_fault && all_red_s;

  // Fault priority encoder, lowest code wins
  always_comb begin
    new_code_s = FC_NONE;
    if (conflict_s) begin
      new_code_s = FC_CONFLICT;
    end else if (|ill_s) begin
      new_code_s = FC_ILLEGAL;
    end else if (|skip_s) begin
      new_code_s = FC_SKIP_AMBER;
    end else if (|short_s) begin
      new_code_s = FC_SHORT_AMBER;
    end else begin
      new_code_s = FC_NONE;
    end
  end

  // Monitor FSM with registered lamps, fault flag and fault code
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= NORMAL;
      tmr_r   <= {TW{1'b0}};
      lit_r   <= 1'b0;
      fault_r <= 1'b0;
      code_r  <= FC_NONE;
      for (int i = 0; i < 4; i++) lamp_r[i] <= RED;
    end else begin
      case (state_r)
        NORMAL: begin
          if (new_code_s != FC_NONE) begin
            state_r <= ALL_RED;
            tmr_r   <= {TW{1'b0}};
            fault_r <= 1'b1;
            code_r  <= new_code_s;
            for (int i = 0; i < 4; i++) lamp_r[i] <= RED;
          end else begin
            for (int i = 0; i < 4; i++) lamp_r[i] <= drive_s[i];
          end
        end
        ALL_RED: begin
          // later faults are ignored here; the first cause stays latched
          if (tmr_r == TW'(ALL_RED_CYC - 1)) begin
            state_r <= FLASH;
            tmr_r   <= {TW{1'b0}};
            lit_r   <= 1'b1;
            for (int i = 0; i < 4; i++) lamp_r[i] <= flash_lamp(i == 3, 1'b1);
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        FLASH: begin
          if (clear_ok_s) begin
            // inputs are all RED here, so RED is also the 1-cycle-late copy
            state_r <= NORMAL;
            tmr_r   <= {TW{1'b0}};
            lit_r   <= 1'b0;
            fault_r <= 1'b0;
            code_r  <= FC_NONE;
            for (int i = 0; i < 4; i++) lamp_r[i] <= RED;
          end else if (tmr_r == TW'(FLASH_HALF - 1)) begin
            tmr_r <= {TW{1'b0}};
            lit_r <= ~lit_r;
            for (int i = 0; i < 4; i++) lamp_r[i] <= flash_lamp(i == 3, ~lit_r);
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        default: begin
          // unreachable encoding: fail safe into all-red with a fault raised
          state_r <= ALL_RED;
          tmr_r   <= {TW{1'b0}};
          fault_r <= 1'b1;
          for (int i = 0; i < 4; i++) lamp_r[i] <= RED;
        end
      endcase
    end
  end

  assign bus.lamp_M1    = lamp_r[0];
  assign bus.lamp_M2    = lamp_r[1];
  assign bus.lamp_MT    = lamp_r[2];
  assign bus.lamp_ST    = lamp_r[3];
  assign bus.fault      = fault_r;
  assign bus.fault_code = code_r;

`ifdef SIGNAL_SAFETY_FAULT_CNT_EN
  logic [7:0] fault_cnt_r;

  // Saturating count of NORMAL -> ALL_RED entries; survives clear_fault
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cnt_r <= 8'd0;
    end else if ((state_r == NORMAL) && (new_code_s != FC_NONE) &&
                 (fault_cnt_r != 8'd255)) begin
      fault_cnt_r <= fault_cnt_r + 8'd1;
    end else begin
      fault_cnt_r <= fault_cnt_r;
    end
  end

  assign bus.fault_cnt = fault_cnt_r;
`endif

endmodule

// File: tb/tb_signal_safety_monitor.sv
// tb_signal_safety_monitor: scoreboard bench for signal_safety_monitor.
// Each stimulus cycle runs a behavioural model that pushes the expected
// registered outputs; a negedge monitor pops and compares them.
module tb_signal_safety_monitor;
  import traffic_pkg::*;

  localparam int MIN_AMBER   = 2;
  localparam int ALL_RED_CYC = 4;
  localparam int FLASH_HALF  = 2;
  localparam int INVALID_TOL = 1;

  typedef struct packed {
    logic [11:0] lamps;
    logic        fault;
    logic [2:0]  code;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // behavioural model state
  logic [2:0] m_hist [4];
  int         m_amb  [4];
  int         m_ill  [4];
  logic [2:0] m_lamp [4];
  bit         m_faulted = 1'b0;
  int         m_age = 0;
  logic [2:0] m_code = 3'd0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  signal_safety_monitor_if bus ();

  signal_safety_monitor #(
    .MIN_AMBER   (MIN_AMBER),
    .ALL_RED_CYC (ALL_RED_CYC),
    .FLASH_HALF  (FLASH_HALF),
    .INVALID_TOL (INVALID_TOL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_lamps();
    return {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_ST};
  endfunction

  task automatic model_clean();
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = RED; m_amb[i] = 0; m_ill[i] = 0; m_lamp[i] = RED;
    end
    m_faulted = 1'b0;
    m_code    = 3'd0;
  endtask

  // Fault-mode lamp pattern as a function of cycles since fault entry (1-based)
  task automatic model_fault_lamps();
    int  ph;
    bit  lit;
    if (m_age <= ALL_RED_CYC) begin
      for (int i = 0; i < 4; i++) m_lamp[i] = RED;
    end else begin
      ph  = ((m_age - ALL_RED_CYC - 1) / FLASH_HALF) % 2;
      lit = (ph == 0);
      for (int i = 0; i < 3; i++) m_lamp[i] = lit ? AMB : OFF;
      m_lamp[3] = lit ? RED : OFF;
    end
  endtask

  task automatic model_step(input logic [2:0] m1, m2, mt, st, input logic clr, input logic r);
    logic [2:0] in [4];
    logic [2:0] drv [4];
    bit conflict, ill, skip, shrt, legal, allred;
    in[0] = m1; in[1] = m2; in[2] = mt; in[3] = st;
    if (r) begin
      model_clean();
      m_cnt = 0;
    end else if (!m_faulted) begin
      conflict = (in[3] == GRN && (in[0] == GRN || in[1] == GRN || in[2] == GRN)) ||
                 (in[1] == GRN && in[2] == GRN);
      ill = 0; skip = 0; shrt = 0;
      for (int i = 0; i < 4; i++) begin
        legal = (in[i] == RED) || (in[i] == AMB) || (in[i] == GRN);
        if (!legal && m_ill[i] >= INVALID_TOL) ill = 1;
        if ((m_hist[i] == GRN && in[i] == RED) || (m_hist[i] == AMB && in[i] == GRN)) skip = 1;
        if (m_hist[i] == AMB && in[i] == RED && m_amb[i] < MIN_AMBER) shrt = 1;
        drv[i]   = legal ? in[i] : m_hist[i];
        m_ill[i] = legal ? 0 : m_ill[i] + 1;
        m_amb[i] = (in[i] == AMB) ? m_amb[i] + 1 : 0;
        if (legal) m_hist[i] = in[i];
      end
      if (conflict || ill || skip || shrt) begin
        m_faulted = 1'b1;
        m_age     = 1;
        m_code    = conflict ? 3'd1 : ill ? 3'd2 : skip ? 3'd3 : 3'd4;
        if (m_cnt < 255) m_cnt++;
        for (int i = 0; i < 4; i++) m_lamp[i] = RED;
      end else begin
        for (int i = 0; i < 4; i++) m_lamp[i] = drv[i];
      end
    end else begin
      allred = (in[0] == RED) && (in[1] == RED) && (in[2] == RED) && (in[3] == RED);
      if (m_age > ALL_RED_CYC && clr && allred) begin
        model_clean();
      end else begin
        m_age++;
        model_fault_lamps();
      end
    end
    exp_q.push_back({m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], m_faulted, m_code, 8'(m_cnt)});
  endtask

  // One clock cycle of stimulus; returns just after the consuming edge
  task automatic cyc(input logic [2:0] m1, m2, mt, st,
                     input logic clr = 1'b0, input logic r = 1'b0);
    model_step(m1, m2, mt, st, clr, r);
    bus.light_M1_in = m1;
    bus.light_M2_in = m2;
    bus.light_MT_in = mt;
    bus.light_ST_in = st;
    bus.clear_fault = clr;
    rst             = r;
    @(posedge clk);
    #1;
  endtask

  task automatic all_red(input int n);
    for (int k = 0; k < n; k++) cyc(RED, RED, RED, RED);
  endtask

  // From the first fault cycle: wait into FLASH and clear with all inputs RED
  task automatic recover();
    all_red(ALL_RED_CYC);
    cyc(RED, RED, RED, RED, 1'b1);
    chk("recover_fault", {15'd0, bus.fault}, 16'd0);
  endtask

  function automatic logic [2:0] pick(input int k);
    logic [2:0] c;
    case (k)
      0:       c = RED;
      1:       c = AMB;
      default: c = GRN;
    endcase
    return c;
  endfunction

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lamps", {4'd0, dut_lamps()}, {4'd0, e.lamps});
      chk("fault", {15'd0, bus.fault}, {15'd0, e.fault});
      chk("fault_code", {13'd0, bus.fault_code}, {13'd0, e.code});
`ifdef SIGNAL_SAFETY_FAULT_CNT_EN
      chk("fault_cnt", {8'd0, bus.fault_cnt}, {8'd0, e.cnt});
`endif
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0] r_in [4];
    model_clean();
    cyc(RED, RED, RED, RED, 1'b0, 1'b1);
    cyc(RED, RED, RED, RED, 1'b0, 1'b1);
    chk("reset_lamps", {4'd0, dut_lamps()}, {4'd0, RED, RED, RED, RED});
    chk("reset_fault", {12'd0, bus.fault, bus.fault_code}, 16'd0);

    // controller-legal sequence
    for (int k = 0; k < 8; k++) cyc(GRN, GRN, RED, RED);
    for (int k = 0; k < 3; k++) cyc(GRN, AMB, RED, RED);
    for (int k = 0; k < 6; k++) cyc(GRN, RED, GRN, RED);
    for (int k = 0; k < 3; k++) cyc(AMB, RED, AMB, RED);
    for (int k = 0; k < 4; k++) cyc(RED, RED, RED, GRN);
    chk("legal_track", {4'd0, dut_lamps()}, {4'd0, RED, RED, RED, GRN});
    for (int k = 0; k < 3; k++) cyc(RED, RED, RED, AMB);
    all_red(1);
    chk("legal_nofault", {15'd0, bus.fault}, 16'd0);

    // conflict, all-red hold, flashing, ignored and accepted clear
    cyc(GRN, RED, RED, RED);
    cyc(GRN, RED, RED, GRN);
    chk("conflict_code", {12'd0, bus.fault, bus.fault_code}, {12'd0, 1'b1, 3'd1});
    chk("conflict_red", {4'd0, dut_lamps()}, {4'd0, RED, RED, RED, RED});
    all_red(4);
    chk("flash_on", {4'd0, dut_lamps()}, {4'd0, AMB, AMB, AMB, RED});
    cyc(GRN, RED, RED, RED, 1'b1);
    chk("clear_ignored", {15'd0, bus.fault}, 16'd1);
    all_red(1);
    chk("flash_off", {4'd0, dut_lamps()}, 16'd0);
    cyc(RED, RED, RED, RED, 1'b1);
    chk("clear_ok", {12'd0, bus.fault, bus.fault_code}, 16'd0);
    cyc(RED, RED, RED, GRN);
    chk("clear_track", {4'd0, dut_lamps()}, {4'd0, RED, RED, RED, GRN});
    cyc(RED, RED, RED, AMB);
    cyc(RED, RED, RED, AMB);
    all_red(1);

    // short amber
    cyc(RED, GRN, RED, RED);
    cyc(RED, AMB, RED, RED);
    cyc(RED, RED, RED, RED);
    chk("short_amber", {13'd0, bus.fault_code}, 16'd4);
    recover();

    // skipped amber
    cyc(RED, GRN, RED, RED);
    cyc(RED, RED, RED, RED);
    chk("skip_amber", {13'd0, bus.fault_code}, 16'd3);
    recover();

    // illegal code tolerated for one cycle, then fault on the second
    cyc(GRN, RED, RED, RED);
    cyc(3'b011, RED, RED, RED);
    chk("illegal_hold", {13'd0, bus.lamp_M1}, {13'd0, GRN});
    cyc(GRN, RED, RED, RED);
    chk("illegal_tol", {15'd0, bus.fault}, 16'd0);
    cyc(3'b011, RED, RED, RED);
    cyc(3'b011, RED, RED, RED);
    chk("illegal_code", {13'd0, bus.fault_code}, 16'd2);
    recover();

    // reset during flashing
    cyc(GRN, RED, RED, GRN);
    all_red(6);
    cyc(RED, RED, RED, RED, 1'b0, 1'b1);
    chk("rst_flash_lamps", {4'd0, dut_lamps()}, {4'd0, RED, RED, RED, RED});
    chk("rst_flash_fault", {12'd0, bus.fault, bus.fault_code}, 16'd0);
    all_red(1);

    // conflict and short amber in the same cycle
    cyc(RED, GRN, RED, RED);
    cyc(GRN, AMB, RED, RED);
    cyc(GRN, RED, RED, GRN);
    chk("simul_code", {13'd0, bus.fault_code}, 16'd1);
    recover();

    // randomized traffic checked by the scoreboard
    for (int i = 0; i < 4; i++) r_in[i] = RED;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(99) < 25) begin
        for (int i = 0; i < 4; i++) r_in[i] = RED;
      end else begin
        for (int i = 0; i < 4; i++) begin
          int k;
          k = $urandom_range(99);
          if (k < 3) r_in[i] = 3'($urandom_range(7));
          else if (k < 30) r_in[i] = pick($urandom_range(2));
        end
      end
      cyc(r_in[0], r_in[1], r_in[2], r_in[3],
          ($urandom_range(99) < 20) ? 1'b1 : 1'b0,
          ($urandom_range(199) == 0) ? 1'b1 : 1'b0);
    end

    all_red(1);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
